// File: rtl/sad_pkg.sv
// Shared constants for the SAD datapath.
// Holds the default element width, memory depth and accumulator width, plus the
// muxsel encodings that choose the direction of the absolute-difference subtract.
package sad_pkg;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned SUM_W  = 16;

    localparam logic MUX_T1_MINUS_T2 = 1'b0;
    localparam logic MUX_T2_MINUS_T1 = 1'b1;
endpackage

// File: rtl/sad_mem.sv
// DEPTH x DATA_W register file: synchronous write, asynchronous read.
// Ports:
//   Clk        clock, write on posedge
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address
//   o_rd_data  combinational read data (old contents during a same-address write)
// Contents are deliberately not reset.
module sad_mem #(
    parameter int unsigned DATA_W = sad_pkg::DATA_W,
    parameter int unsigned DEPTH  = sad_pkg::DEPTH,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sad_datapath.sv
// Sum-of-absolute-differences datapath driven by an external controller.
// Ports:
//   Clk, Rst                      clock, asynchronous active-high reset
//   i_clr, i_ld                   index clear / saturating increment
//   temp1_clr/ld, temp2_clr/ld    operand register clear / load from memory A / B
//   sum_clr, sum_ld               accumulator clear / accumulate diff
//   muxsel                        0: temp1-temp2, 1: temp2-temp1
//   R_en                          memory read enable
//   done                          capture accumulator into sad_out
//   wr_en, wr_sel, wr_addr, wr_data  host write port (wr_sel 0 = A, 1 = B)
//   temp1_gt_temp2                unsigned temp1 > temp2
//   i_lt_32                       index below DEPTH
//   sad_out                       registered result
module sad_datapath #(
    parameter int unsigned DATA_W = sad_pkg::DATA_W,
    parameter int unsigned DEPTH  = sad_pkg::DEPTH,
    parameter int unsigned SUM_W  = sad_pkg::SUM_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              i_clr,
    input  logic              i_ld,
    input  logic              temp1_clr,
    input  logic              temp1_ld,
    input  logic              temp2_clr,
    input  logic              temp2_ld,
    input  logic              sum_clr,
    input  logic              sum_ld,
    input  logic              muxsel,
    input  logic              R_en,
    input  logic              done,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              temp1_gt_temp2,
    output logic              i_lt_32,
    output logic [SUM_W-1:0]  sad_out
);
    import sad_pkg::*;

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned ADDR_W = 5;

    logic [IDX_W-1:0]  r_i;
    logic [DATA_W-1:0] r_temp1;
    logic [DATA_W-1:0] r_temp2;
    logic [SUM_W-1:0]  r_sum;
    logic [SUM_W-1:0]  r_sad;

    logic              w_i_lt;
    logic              w_rd_en;
    logic [DATA_W-1:0] w_mem_a;
    logic [DATA_W-1:0] w_mem_b;
    logic [DATA_W-1:0] w_a_rd;
    logic [DATA_W-1:0] w_b_rd;
    logic [DATA_W-1:0] w_diff;
    logic [SUM_W-1:0]  w_diff_ext;

    assign w_i_lt  = (r_i < IDX_W'(DEPTH));
    // Reads past the end of the table return zero rather than aliasing entry 0.
    assign w_rd_en = R_en & w_i_lt;
    assign w_a_rd  = w_rd_en ? w_mem_a : '0;
    assign w_b_rd  = w_rd_en ? w_mem_b : '0;

    // Subtract wraps in DATA_W bits; the controller picks the direction so the
    // result is the absolute difference.
    assign w_diff     = (muxsel == MUX_T2_MINUS_T1) ? (r_temp2 - r_temp1) : (r_temp1 - r_temp2);
    assign w_diff_ext = SUM_W'(w_diff);

    sad_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem_a (
        .Clk       (Clk),
        .i_wr_en   (wr_en & (wr_sel == 1'b0)),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_i[ADDR_W-1:0]),
        .o_rd_data (w_mem_a)
    );

    sad_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem_b (
        .Clk       (Clk),
        .i_wr_en   (wr_en & (wr_sel == 1'b1)),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_i[ADDR_W-1:0]),
        .o_rd_data (w_mem_b)
    );

    // Index saturates at DEPTH so a stray increment never wraps back into range.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_i <= '0;
        end else if (i_clr) begin
            r_i <= '0;
        end else if (i_ld && w_i_lt) begin
            r_i <= r_i + IDX_W'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_temp1 <= '0;
            r_temp2 <= '0;
        end else begin
            if (temp1_clr)     r_temp1 <= '0;
            else if (temp1_ld) r_temp1 <= w_a_rd;
            if (temp2_clr)     r_temp2 <= '0;
            else if (temp2_ld) r_temp2 <= w_b_rd;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_sum <= '0;
            r_sad <= '0;
        end else begin
            if (sum_clr)     r_sum <= '0;
            else if (sum_ld) r_sum <= r_sum + w_diff_ext;
            if (done)        r_sad <= r_sum;
        end
    end

    assign i_lt_32        = w_i_lt;
    assign temp1_gt_temp2 = (r_temp1 > r_temp2);
    assign sad_out        = r_sad;

endmodule

// File: tb/tb_sad_datapath.sv
// Directed self-checking bench for sad_datapath.
module tb_sad_datapath;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        i_clr, i_ld, temp1_clr, temp1_ld, temp2_clr, temp2_ld;
    logic        sum_clr, sum_ld, muxsel, R_en, done;
    logic        wr_en, wr_sel;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        temp1_gt_temp2, i_lt_32;
    logic [15:0] sad_out;
    logic [15:0] v;

    int n_checks = 0;
    int n_fail   = 0;

    sad_datapath #(
        .DATA_W (8),
        .DEPTH  (32),
        .SUM_W  (16)
    ) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .i_clr          (i_clr),
        .i_ld           (i_ld),
        .temp1_clr      (temp1_clr),
        .temp1_ld       (temp1_ld),
        .temp2_clr      (temp2_clr),
        .temp2_ld       (temp2_ld),
        .sum_clr        (sum_clr),
        .sum_ld         (sum_ld),
        .muxsel         (muxsel),
        .R_en           (R_en),
        .done           (done),
        .wr_en          (wr_en),
        .wr_sel         (wr_sel),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .temp1_gt_temp2 (temp1_gt_temp2),
        .i_lt_32        (i_lt_32),
        .sad_out        (sad_out)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_ctrl();
        i_clr = 0; i_ld = 0; temp1_clr = 0; temp1_ld = 0; temp2_clr = 0; temp2_ld = 0;
        sum_clr = 0; sum_ld = 0; muxsel = 0; R_en = 0; done = 0;
        wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic mem_write(input logic sel, input logic [4:0] addr, input logic [7:0] data);
        wr_en = 1; wr_sel = sel; wr_addr = addr; wr_data = data;
        step();
        wr_en = 0;
    endtask

    task automatic capture(output logic [15:0] res);
        done = 1;
        step();
        done = 0;
        res = sad_out;
    endtask

    // Returns temp1 - temp2 (mod 256) through the accumulator and result register.
    task automatic probe_diff(output logic [15:0] res);
        sum_clr = 1;
        step();
        sum_clr = 0; sum_ld = 1; muxsel = 0;
        step();
        sum_ld = 0;
        capture(res);
    endtask

    task automatic set_index(input int n);
        i_clr = 1;
        step();
        i_clr = 0; i_ld = 1;
        repeat (n) step();
        i_ld = 0;
    endtask

    task automatic load_t1_only();
        R_en = 1; temp1_ld = 1;
        step();
        R_en = 0; temp1_ld = 0;
    endtask

    task automatic run_loop(input int n_iter, input bit chk_not_gt);
        i_clr = 1; sum_clr = 1;
        step();
        i_clr = 0; sum_clr = 0;
        for (int it = 0; it < n_iter; it++) begin
            R_en = 1; temp1_ld = 1; temp2_ld = 1;
            step();
            R_en = 0; temp1_ld = 0; temp2_ld = 0;
            if (chk_not_gt) check_eq("loop_gt_low", temp1_gt_temp2, 0);
            muxsel = temp1_gt_temp2 ? 1'b0 : 1'b1;
            sum_ld = 1; i_ld = 1;
            step();
            sum_ld = 0; i_ld = 0;
        end
    endtask

    initial begin
        idle_ctrl();
        Rst = 1;
        #12;
        check_eq("rst_sad_out", sad_out, 0);
        check_eq("rst_gt", temp1_gt_temp2, 0);
        Rst = 0;
        step();
        check_eq("rst_i_lt_32", i_lt_32, 1);

        // Ramp against zero: sum of 0..31.
        for (int k = 0; k < 32; k++) begin
            mem_write(0, 5'(k), 8'(k));
            mem_write(1, 5'(k), 8'd0);
        end
        run_loop(32, 0);
        check_eq("loop_end_i_lt", i_lt_32, 0);
        capture(v);
        check_eq("sad_ramp", v, 496);

        // Same-cycle write/read of A[3] returns old data, then new.
        set_index(3);
        wr_en = 1; wr_sel = 0; wr_addr = 5'd3; wr_data = 8'h55;
        R_en = 1; temp1_ld = 1; temp2_clr = 1;
        step();
        wr_en = 0; R_en = 0; temp1_ld = 0; temp2_clr = 0;
        probe_diff(v);
        check_eq("rw_old", v, 3);
        load_t1_only();
        probe_diff(v);
        check_eq("rw_new", v, 8'h55);

        // Reset mid-loop at i=17.
        run_loop(17, 0);
        check_eq("mid_gt", temp1_gt_temp2, 1);
        check_eq("mid_sad_pre", sad_out, 8'h55);
        #3 Rst = 1;
        #1;
        check_eq("mid_rst_sad", sad_out, 0);
        check_eq("mid_rst_gt", temp1_gt_temp2, 0);
        Rst = 0;
        capture(v);
        check_eq("mid_rst_sum", v, 0);
        i_ld = 1;
        step();
        i_ld = 0;
        load_t1_only();
        probe_diff(v);
        check_eq("mid_rst_i", v, 1);
        run_loop(32, 0);
        capture(v);
        check_eq("mem_kept", v, 496 - 3 + 8'h55);

        // temp1 < temp2 everywhere, muxsel=1 path.
        for (int k = 0; k < 32; k++) begin
            mem_write(0, 5'(k), 8'd10);
            mem_write(1, 5'(k), 8'd20);
        end
        run_loop(32, 1);
        capture(v);
        check_eq("sad_neg", v, 320);
        sum_clr = 1;
        step();
        sum_clr = 0;
        step();
        check_eq("sad_hold", sad_out, 320);
        capture(v);
        check_eq("sad_after_clr", v, 0);

        // Index boundary and saturation.
        mem_write(0, 5'd0, 8'd200);
        mem_write(1, 5'd0, 8'd7);
        i_clr = 1;
        step();
        i_clr = 0; R_en = 1; temp1_ld = 1; temp2_ld = 1;
        step();
        R_en = 0; temp1_ld = 0; temp2_ld = 0;
        check_eq("bnd_gt", temp1_gt_temp2, 1);
        for (int p = 1; p <= 64; p++) begin
            i_ld = 1;
            step();
            i_ld = 0;
            if (p == 31) check_eq("bnd_31", i_lt_32, 1);
            if (p == 32) check_eq("bnd_32", i_lt_32, 0);
            if (p == 33) check_eq("bnd_33", i_lt_32, 0);
        end
        check_eq("bnd_64", i_lt_32, 0);
        load_t1_only();
        check_eq("bnd_rd_gt", temp1_gt_temp2, 0);
        probe_diff(v);
        check_eq("bnd_rd_zero", v, 249);

        // Simultaneous clear and load on i, temp1 and sum.
        set_index(5);
        R_en = 1; temp1_ld = 1; temp2_clr = 1;
        step();
        R_en = 0; temp1_ld = 0; temp2_clr = 0; sum_clr = 1;
        step();
        sum_clr = 0; sum_ld = 1; muxsel = 0;
        step();
        i_clr = 1; i_ld = 1; temp1_clr = 1; temp1_ld = 1; R_en = 1; sum_clr = 1; sum_ld = 1;
        step();
        idle_ctrl();
        check_eq("clr_t1_gt", temp1_gt_temp2, 0);
        capture(v);
        check_eq("clr_sum", v, 0);
        load_t1_only();
        probe_diff(v);
        check_eq("clr_i", v, 200);

        // Difference wraps in 8 bits; accumulator wraps in 16 bits.
        mem_write(0, 5'd0, 8'd255);
        i_clr = 1;
        step();
        i_clr = 0; R_en = 1; temp1_ld = 1; temp2_clr = 1;
        step();
        R_en = 0; temp1_ld = 0; temp2_clr = 0; sum_clr = 1;
        step();
        sum_clr = 0; sum_ld = 1; muxsel = 1;
        step();
        sum_ld = 0;
        capture(v);
        check_eq("diff_wrap", v, 1);
        sum_clr = 1;
        step();
        sum_clr = 0; sum_ld = 1; muxsel = 0;
        repeat (258) step();
        sum_ld = 0;
        capture(v);
        check_eq("sum_wrap", v, 254);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sad_datapath.md
SAD_DATAPATH -- requirements
Module: sad_datapath

Interface
REQ-001 Parameters: DATA_W, default 8, element width; DEPTH, default 32, entries per memory; SUM_W, default 16, accumulator width.
REQ-002 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-003 Rst  in  1  reset, asynchronous, active-high.
REQ-004 i_clr, i_ld  in  1 each  index counter clear and increment.
REQ-005 temp1_clr, temp1_ld, temp2_clr, temp2_ld  in  1 each  operand register clear and load.
REQ-006 sum_clr, sum_ld  in  1 each  accumulator clear and accumulate.
REQ-007 muxsel  in  1  difference direction: 0 = temp1-temp2, 1 = temp2-temp1.
REQ-008 R_en  in  1  memory read enable.
REQ-009 done  in  1  controller completion strobe; captures the result.
REQ-010 wr_en, wr_sel  in  1 each  host write strobe and target select: 0 = memory A, 1 = memory B.
REQ-011 wr_addr  in  5; wr_data  in  DATA_W  host write address and data.
REQ-012 temp1_gt_temp2  out  1  status: temp1 > temp2, unsigned.
REQ-013 i_lt_32  out  1  status: i < DEPTH.
REQ-014 sad_out  out  SUM_W  registered SAD result.

Function
REQ-015 Index i SHALL be 6 bits; i_clr sets it to 0; i_ld increments it; i_ld at i=32 holds 32 (saturates); i_clr overrides i_ld.
REQ-016 i_lt_32 SHALL be combinational from i, with no added latency.
REQ-017 Read data SHALL be combinational: A_rd = mem_A[i[4:0]] and B_rd = mem_B[i[4:0]] when R_en=1 and i<32, else 0.
REQ-018 temp1_ld SHALL load A_rd and temp2_ld SHALL load B_rd on the next edge; clr overrides ld; with neither asserted, the register holds.
REQ-019 temp1_gt_temp2 SHALL be combinational, unsigned compare of the registered temp1 and temp2.
REQ-020 diff SHALL be (muxsel ? temp2-temp1 : temp1-temp2), DATA_W bits, zero-extended to SUM_W.
REQ-021 sum_ld SHALL perform sum <= sum + diff modulo 2^SUM_W; sum_clr overrides sum_ld.
REQ-022 done=1 SHALL load sad_out <= sum on the edge; sad_out SHALL otherwise hold.
REQ-023 sad_out SHALL hold its value across a following sum_clr until the next done.
REQ-024 wr_en=1 SHALL write wr_data to the selected memory at wr_addr on the edge.
REQ-025 A read of the same address in the cycle of a write SHALL return the old data; the new data SHALL be visible from the next cycle.
REQ-026 Writes and reads SHALL be allowed in the same cycle with no stall; wr_en and the control inputs are independent.

Reset
REQ-027 Rst=1 SHALL asynchronously set i, temp1, temp2, sum and sad_out to 0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Rst asserted mid-accumulation SHALL abort the accumulation.
REQ-030 After Rst deasserts, i_lt_32=1 and temp1_gt_temp2=0.

Structure
REQ-031 A shared package sad_pkg SHALL hold DATA_W, DEPTH, SUM_W and the muxsel encodings (MUX_T1_MINUS_T2=0, MUX_T2_MINUS_T1=1).
REQ-032 One sub-module, sad_mem, SHALL implement a DEPTH x DATA_W register file with a synchronous write and an asynchronous read.
REQ-033 sad_mem SHALL be instantiated twice, once for A and once for B.

Verification
REQ-034 Load A[k]=k and B[k]=0 for k=0..31; run a full loop of i_clr, then per i: R_en+temp1_ld+temp2_ld, then sum_ld with muxsel per temp1_gt_temp2; assert done -> sad_out=496.
REQ-035 A[k]=10, B[k]=20 for all k, full loop -> temp1_gt_temp2=0 every iteration; sad_out=320 using muxsel=1.
REQ-036 Index boundary: 32 pulses of i_ld -> i_lt_32 falls on the 32nd edge; a 33rd i_ld -> i stays 32; R_en at i=32 -> temp1 loads 0.
REQ-037 Simultaneous clr+ld on i, temp1 and sum -> all three are 0 after the edge.
REQ-038 Write A[3]=0x55 while reading i=3 -> temp1 loads the old value; the next-cycle load gives 0x55.
REQ-039 Rst pulse mid-loop (i=17, sum nonzero), asserted between edges -> i, sum and sad_out go to 0 immediately; memories keep their data.
